// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI receive path: command opcodes,
// decoder state encoding and the RGB565 pixel type.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_SKIP
  } dec_state_t;

  typedef logic [15:0] rgb565_t;

  // Any command byte restarts decoding from the state it selects.
  function automatic dec_state_t dispatch(input logic [7:0] cmd);
    case (cmd)
      CMD_CASET: return ST_CASET;
      CMD_PASET: return ST_PASET;
      CMD_RAMWR: return ST_RAMWR;
      default:   return ST_SKIP;
    endcase
  endfunction

endpackage

// File: rtl/tft_spi_deser.sv
// Passive SPI mode-0 byte deserialiser: synchronises the bus into clk,
// detects spi_clk rising edges and assembles MSB-first bytes.
module tft_spi_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] clk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] dc_sync;
  logic [1:0] cs_sync;
  logic       clk_prev;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       clk_rise;

  assign clk_rise = clk_sync[1] & ~clk_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= 2'b00;
      mosi_sync  <= 2'b00;
      dc_sync    <= 2'b00;
      cs_sync    <= 2'b11;
      clk_prev   <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], spi_clk};
      mosi_sync  <= {mosi_sync[0], spi_mosi};
      dc_sync    <= {dc_sync[0], spi_dc};
      cs_sync    <= {cs_sync[0], spi_cs};
      clk_prev   <= clk_sync[1];
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        // Deselect discards any partial byte.
        shift   <= '0;
        bit_cnt <= '0;
      end else if (clk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shift, mosi_sync[1]};
          byte_dc    <= dc_sync[1];
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tft_spi_rx.sv
// TFT SPI bus monitor: byte deserialiser plus, with TFT_SPI_RX_PIXEL_DECODE_EN
// defined, a CASET/PASET/RAMWR decoder producing addressed RGB565 pixels.
module tft_spi_rx
  import tft_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_cs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [15:0]        pixel_color,
  output logic               ramwr_active
);

  tft_spi_deser u_deser (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  // Pixel coordinates are the low bits of 16-bit window values.
  if (WIDTH < 1 || HEIGHT < 1 || COORD_W < 1 || COORD_W > 16) begin : g_bad_geometry
  end

`ifdef TFT_SPI_RX_PIXEL_DECODE_EN

  localparam logic [15:0] X_END_RST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_END_RST = 16'(HEIGHT - 1);

  dec_state_t  state, state_next;
  logic [1:0]  arg_cnt;
  logic [23:0] arg_buf;
  logic [15:0] x_start, x_end, y_start, y_end;
  logic [15:0] cur_x, cur_y;
  logic        lo_phase;
  logic [7:0]  hi_byte;
  rgb565_t     color_next;

  assign color_next   = {hi_byte, byte_data};
  assign ramwr_active = (state == ST_RAMWR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment before any branch keeps this block free of
  // inferred latches.
  always_comb begin
    state_next = state;
    if (byte_valid) begin
      if (!byte_dc) begin
        state_next = dispatch(byte_data);
      end else if ((state == ST_CASET || state == ST_PASET) && arg_cnt == 2'd3) begin
        state_next = ST_SKIP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_cnt     <= '0;
      arg_buf     <= '0;
      x_start     <= '0;
      x_end       <= X_END_RST;
      y_start     <= '0;
      y_end       <= Y_END_RST;
      cur_x       <= '0;
      cur_y       <= '0;
      lo_phase    <= 1'b0;
      hi_byte     <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          arg_cnt  <= '0;
          lo_phase <= 1'b0;
          if (byte_data == CMD_RAMWR) begin
            cur_x <= x_start;
            cur_y <= y_start;
          end
        end else begin
          case (state)
            ST_CASET, ST_PASET: begin
              arg_cnt <= arg_cnt + 2'd1;
              if (arg_cnt == 2'd3) begin
                // Window commits atomically on the fourth argument only.
                if (state == ST_CASET) begin
                  x_start <= arg_buf[23:8];
                  x_end   <= {arg_buf[7:0], byte_data};
                end else begin
                  y_start <= arg_buf[23:8];
                  y_end   <= {arg_buf[7:0], byte_data};
                end
              end else begin
                arg_buf <= {arg_buf[15:0], byte_data};
              end
            end
            ST_RAMWR: begin
              if (!lo_phase) begin
                hi_byte  <= byte_data;
                lo_phase <= 1'b1;
              end else begin
                lo_phase    <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_x     <= cur_x[COORD_W-1:0];
                pixel_y     <= cur_y[COORD_W-1:0];
                pixel_color <= color_next;
                if (cur_x >= x_end) begin
                  cur_x <= x_start;
                  cur_y <= (cur_y >= y_end) ? y_start : cur_y + 16'd1;
                end else begin
                  cur_x <= cur_x + 16'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`else

  assign pixel_valid  = 1'b0;
  assign pixel_x      = '0;
  assign pixel_y      = '0;
  assign pixel_color  = '0;
  assign ramwr_active = 1'b0;

`endif

endmodule

// File: tb/tb_tft_spi_rx.sv
// Self-checking bench for tft_spi_rx: directed and random SPI traffic
// compared against a window/pixel-index reference model.
module tb_tft_spi_rx;

  localparam int WIDTH   = 320;
  localparam int HEIGHT  = 480;
  localparam int COORD_W = 9;

`ifdef TFT_SPI_RX_PIXEL_DECODE_EN
  localparam bit DECODE_EN = 1'b1;
`else
  localparam bit DECODE_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               spi_clk = 1'b0;
  logic               spi_mosi = 1'b0;
  logic               spi_dc = 1'b0;
  logic               spi_cs = 1'b1;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_dc;
  logic               pixel_valid;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [15:0]        pixel_color;
  logic               ramwr_active;

  tft_spi_rx #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_dc       (spi_dc),
    .spi_cs       (spi_cs),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_dc      (byte_dc),
    .pixel_valid  (pixel_valid),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_color  (pixel_color),
    .ramwr_active (ramwr_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dc;
    logic [7:0]  data;
    logic [31:0] cyc;
  } byte_ev_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [15:0]        color;
  } pix_ev_t;

  byte_ev_t obs_bytes[$], exp_bytes[$];
  pix_ev_t  obs_pix[$],   exp_pix[$];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid)  obs_bytes.push_back('{byte_dc, byte_data, cyc});
      if (pixel_valid) obs_pix.push_back('{pixel_x, pixel_y, pixel_color});
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: window plus a running pixel index inside RAMWR.
  int m_mode;  // 0 idle, 1 caset, 2 paset, 3 ramwr, 4 skip
  int m_args[$];
  int m_hi;
  int m_xs, m_xe, m_ys, m_ye;
  int m_npix;

  task automatic model_reset();
    m_mode = 0;
    m_args.delete();
    m_hi   = -1;
    m_xs   = 0;
    m_xe   = WIDTH - 1;
    m_ys   = 0;
    m_ye   = HEIGHT - 1;
    m_npix = 0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b);
    int w, h, px, py, s, e;
    if (!dc) begin
      m_args.delete();
      m_hi = -1;
      case (b)
        8'h2A:   m_mode = 1;
        8'h2B:   m_mode = 2;
        8'h2C:   begin m_mode = 3; m_npix = 0; end
        default: m_mode = 4;
      endcase
    end else begin
      case (m_mode)
        1, 2: begin
          m_args.push_back(int'(b));
          if (m_args.size() == 4) begin
            s = m_args[0] * 256 + m_args[1];
            e = m_args[2] * 256 + m_args[3];
            if (m_mode == 1) begin m_xs = s; m_xe = e; end
            else             begin m_ys = s; m_ye = e; end
            m_mode = 4;
          end
        end
        3: begin
          if (m_hi < 0) begin
            m_hi = int'(b);
          end else begin
            w  = m_xe - m_xs + 1;
            h  = m_ye - m_ys + 1;
            px = m_xs + m_npix % w;
            py = m_ys + (m_npix / w) % h;
            if (DECODE_EN)
              exp_pix.push_back('{COORD_W'(px), COORD_W'(py), {8'(m_hi), b}});
            m_npix++;
            m_hi = -1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    logic [31:0] rise;
    rise = '0;
    @(negedge clk);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      if (i == 0) rise = cyc;
      repeat (2) @(negedge clk);
      spi_clk = 1'b0;
    end
    exp_bytes.push_back('{dc, b, rise + 32'd3});
    model_byte(dc, b);
  endtask

  task automatic send_partial(input int nbits, input logic [7:0] b);
    @(negedge clk);
    spi_dc = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      repeat (2) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd_args(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, s[15:8]);
    send_byte(1'b1, s[7:0]);
    send_byte(1'b1, e[15:8]);
    send_byte(1'b1, e[7:0]);
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (8) @(negedge clk);
    chk({tag, " byte_count"}, 64'(obs_bytes.size()), 64'(exp_bytes.size()));
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " byte"}, 64'({obs_bytes[i].dc, obs_bytes[i].data}),
          64'({exp_bytes[i].dc, exp_bytes[i].data}));
      chk({tag, " byte_latency"}, 64'(obs_bytes[i].cyc), 64'(exp_bytes[i].cyc));
    end
    chk({tag, " pixel_count"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++)
      chk({tag, " pixel"}, 64'(obs_pix[i]), 64'(exp_pix[i]));
    obs_bytes.delete();
    exp_bytes.delete();
    obs_pix.delete();
    exp_pix.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst byte_valid",   64'(byte_valid),   64'(0));
    chk("rst byte_data",    64'(byte_data),    64'(0));
    chk("rst byte_dc",      64'(byte_dc),      64'(0));
    chk("rst pixel_valid",  64'(pixel_valid),  64'(0));
    chk("rst pixel_x",      64'(pixel_x),      64'(0));
    chk("rst pixel_y",      64'(pixel_y),      64'(0));
    chk("rst pixel_color",  64'(pixel_color),  64'(0));
    chk("rst ramwr_active", 64'(ramwr_active), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_bytes.delete();
    exp_bytes.delete();
    obs_pix.delete();
    exp_pix.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);

    // Window 10..11 x 5..5, three pixels with wrap back to the start.
    send_cmd_args(8'h2A, 16'd10, 16'd11);
    send_cmd_args(8'h2B, 16'd5, 16'd5);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h07); send_byte(1'b1, 8'hE0);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h1F);
    compare("window");
    chk("ramwr_active in stream", 64'(ramwr_active), 64'(DECODE_EN));

    // Single data byte latency.
    send_byte(1'b1, 8'hA5);
    compare("a5_latency");

    // Partial byte dropped by deselect.
    send_partial(5, 8'hFF);
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(1'b1, 8'h3C);
    compare("partial");

    // Truncated CASET leaves the reset window in place.
    do_reset();
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h00);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
    compare("short_caset");
    send_byte(1'b0, 8'h00);
    repeat (8) @(negedge clk);
    chk("ramwr_active after nop", 64'(ramwr_active), 64'(0));
    compare("nop");

    // Full row of the reset window, then first pixel of row 1.
    do_reset();
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 2 * WIDTH + 2; i++) send_byte(1'b1, 8'($urandom));
    compare("full_row");

    // Reset with a dangling hi byte must not leak a pixel.
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    compare("pre_reset");
    do_reset();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    compare("post_reset");

    // Random small windows, stray commands and random pixel data.
    for (int r = 0; r < 4; r++) begin
      int xs, ys, np;
      xs = $urandom_range(0, 300);
      ys = $urandom_range(0, 460);
      send_cmd_args(8'h2A, 16'(xs), 16'(xs + $urandom_range(0, 3)));
      send_cmd_args(8'h2B, 16'(ys), 16'(ys + $urandom_range(0, 2)));
      send_byte(1'b0, 8'h11);
      send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, 8'h2C);
      np = $urandom_range(4, 12);
      for (int i = 0; i < 2 * np + int'($urandom_range(0, 1)); i++)
        send_byte(1'b1, 8'($urandom));
      compare("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
